// File: rtl/memwb_pipereg_if.sv
// MEM/WB pipeline register bus: MEM-stage inputs, stall/flush control and WB-stage outputs.
interface memwb_pipereg_if #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 32,
    parameter int RWIDTH   = 5,
    parameter int CNTWIDTH = 32
);
    logic                stall;
    logic                flush;
    logic                validin;
    logic [1:0]          memtoregin;
    logic                regwrin;
    logic                finin;
    logic [RWIDTH-1:0]   regdstmuxin;
    logic [DWIDTH-1:0]   aluoutin;
    logic [DWIDTH-1:0]   dmdatain;
    logic [AWIDTH-1:0]   pcnextin;
    logic                negativein;

    logic                validout;
    logic                regwrout;
    logic [RWIDTH-1:0]   regdstout;
    logic [DWIDTH-1:0]   wbdataout;
    logic                fwdvalid;
    logic [DWIDTH-1:0]   fwddata;
    logic                finout;
    logic                halted;
    logic [CNTWIDTH-1:0] retired;

    modport master (
        output stall, flush, validin, memtoregin, regwrin, finin,
               regdstmuxin, aluoutin, dmdatain, pcnextin, negativein,
        input  validout, regwrout, regdstout, wbdataout, fwdvalid,
               fwddata, finout, halted, retired
    );

    modport slave (
        input  stall, flush, validin, memtoregin, regwrin, finin,
               regdstmuxin, aluoutin, dmdatain, pcnextin, negativein,
        output validout, regwrout, regdstout, wbdataout, fwdvalid,
               fwddata, finout, halted, retired
    );
endinterface

// File: rtl/memwb_pipereg.sv
// semiMIPS MEM/WB pipeline register with stall/flush, valid gating, writeback mux,
// WB forwarding port, sticky halt on the finish marker and a retired-instruction counter.
module memwb_pipereg #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 32,
    parameter int RWIDTH   = 5,
    parameter int CNTWIDTH = 32
) (
    input  logic           clk,
    input  logic           rstn,
    memwb_pipereg_if.slave bus
);
    localparam logic [CNTWIDTH-1:0] CNT_ONE = 1;

    logic                valid;
    logic [1:0]          memtoreg;
    logic                regwr;
    logic                fin;
    logic [RWIDTH-1:0]   regdst;
    logic [DWIDTH-1:0]   aluout;
    logic [DWIDTH-1:0]   dmdata;
    logic [AWIDTH-1:0]   pcnext;
    logic                negative;
    logic                is_new;
    logic                halted_q;
    logic [CNTWIDTH-1:0] retired_q;
    logic [DWIDTH-1:0]   wbdata;
    logic                fin_retire;

    assign fin_retire = valid & fin;

    // A retiring finish marker halts on the same edge, overriding stall and flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid    <= 1'b0;
            memtoreg <= '0;
            regwr    <= 1'b0;
            fin      <= 1'b0;
            regdst   <= '0;
            aluout   <= '0;
            dmdata   <= '0;
            pcnext   <= '0;
            negative <= 1'b0;
            is_new   <= 1'b0;
            halted_q <= 1'b0;
        end else if (halted_q || fin_retire) begin
            valid    <= 1'b0;
            is_new   <= 1'b0;
            halted_q <= 1'b1;
        end else if (bus.flush) begin
            valid  <= 1'b0;
            regwr  <= 1'b0;
            fin    <= 1'b0;
            is_new <= 1'b0;
        end else if (bus.stall) begin
            is_new <= 1'b0;
        end else begin
            valid    <= bus.validin;
            memtoreg <= bus.memtoregin;
            regwr    <= bus.regwrin;
            fin      <= bus.finin;
            regdst   <= bus.regdstmuxin;
            aluout   <= bus.aluoutin;
            dmdata   <= bus.dmdatain;
            pcnext   <= bus.pcnextin;
            negative <= bus.negativein;
            is_new   <= bus.validin;
        end
    end

    // is_new marks the first cycle an entry sits in WB, so a stalled entry counts once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            retired_q <= '0;
        end else if (valid && is_new) begin
            retired_q <= retired_q + CNT_ONE;
        end
    end

    always_comb begin
        wbdata = '0;
        case (memtoreg)
            2'b00:   wbdata = aluout;
            2'b01:   wbdata = dmdata;
            2'b10:   wbdata[AWIDTH-1:0] = pcnext;
            default: wbdata[0] = negative;
        endcase
    end

    assign bus.validout  = valid;
    assign bus.regwrout  = valid & regwr;
    assign bus.regdstout = regdst;
    assign bus.wbdataout = wbdata;
    assign bus.fwdvalid  = valid & regwr & (regdst != '0);
    assign bus.fwddata   = wbdata;
    assign bus.finout    = fin_retire;
    assign bus.halted    = halted_q;
    assign bus.retired   = retired_q;
endmodule
